// File: rtl/id_operand_fetch.sv
// Decode-side operand fetch: accepts an instruction from IF, reads rs/rt from the
// register file with one-cycle read latency, and offers an operand bundle to EX.
module id_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [DATA_W-1:0] inst,
  input  logic [DATA_W-1:0] inst_pc,
  output logic              re1,
  output logic              re2,
  output logic [AW-1:0]     reg1_addr,
  output logic [AW-1:0]     reg2_addr,
  input  logic [DATA_W-1:0] reg1_data,
  input  logic [DATA_W-1:0] reg2_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_inst,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [AW-1:0]     ex_waddr,
  output logic              ex_wreg,
  output logic              ex_illegal
);

  typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;

  logic              dec_re1, dec_re2, dec_wreg, dec_illegal;
  logic [AW-1:0]     dec_waddr;
  logic [DATA_W-1:0] dec_imm;
  logic [5:0]        op, funct;
  logic              accept, rd_phase;

  assign op    = inst_q[31:26];
  assign funct = inst_q[5:0];

  always_comb begin
    dec_re1     = 1'b0;
    dec_re2     = 1'b0;
    dec_wreg    = 1'b0;
    dec_illegal = 1'b0;
    dec_waddr   = '0;
    dec_imm     = {{(DATA_W-16){inst_q[15]}}, inst_q[15:0]};
    unique case (op)
      6'h00: begin
        dec_re1   = 1'b1;
        dec_re2   = (funct != 6'h08);
        dec_waddr = inst_q[15:11];
        dec_wreg  = (funct != 6'h08);
      end
      6'h08, 6'h09, 6'h0A, 6'h23: begin
        dec_re1   = 1'b1;
        dec_waddr = inst_q[20:16];
        dec_wreg  = 1'b1;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec_re1   = 1'b1;
        dec_waddr = inst_q[20:16];
        dec_wreg  = 1'b1;
        dec_imm   = {{(DATA_W-16){1'b0}}, inst_q[15:0]};
      end
      6'h0F: begin
        dec_waddr = inst_q[20:16];
        dec_wreg  = 1'b1;
        dec_imm   = {inst_q[15:0], {(DATA_W-16){1'b0}}};
      end
      6'h2B, 6'h04, 6'h05: begin
        dec_re1 = 1'b1;
        dec_re2 = 1'b1;
      end
      6'h02: ;
      6'h03: begin
        dec_waddr = AW'(31);
        dec_wreg  = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
        dec_imm     = '0;
      end
    endcase
    if (dec_waddr == '0) dec_wreg = 1'b0;
  end

  // Flush overrides every handshake and read request in the cycle it is raised.
  assign rd_phase   = (state_q == RD || state_q == CAP) && !flush;
  assign re1        = rd_phase && dec_re1;
  assign re2        = rd_phase && dec_re2;
  assign reg1_addr  = rd_phase ? inst_q[25:21] : '0;
  assign reg2_addr  = rd_phase ? inst_q[20:16] : '0;
  assign inst_ready = !flush && (state_q == IDLE || (state_q == OUT && ex_ready));
  assign ex_valid   = (state_q == OUT) && !flush;
  assign accept     = inst_valid && inst_ready;

  assign ex_inst    = inst_q;
  assign ex_pc      = pc_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = dec_imm;
  assign ex_waddr   = dec_waddr;
  assign ex_wreg    = dec_wreg;
  assign ex_illegal = dec_illegal;

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    if (accept) begin
      inst_d = inst;
      pc_d   = inst_pc;
    end
    unique case (state_q)
      IDLE: if (accept) state_d = RD;
      RD:   state_d = CAP;
      CAP: begin
        state_d   = OUT;
        rs_data_d = re1 ? reg1_data : '0;
        rt_data_d = re2 ? reg2_data : '0;
      end
      OUT: if (ex_ready) state_d = inst_valid ? RD : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
    end
  end

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed bench for id_operand_fetch with a behavioural 2R/1W register file
// (one-cycle read latency, same-edge write bypass, r0 hard-wired to zero).
module tb_id_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_n, flush, inst_valid, ex_ready;
  logic [31:0] inst, inst_pc;
  logic        inst_ready, re1, re2, ex_valid, ex_wreg, ex_illegal;
  logic [4:0]  reg1_addr, reg2_addr, ex_waddr;
  logic [31:0] reg1_data, reg2_data;
  logic [31:0] ex_inst, ex_pc, ex_rs_data, ex_rt_data, ex_imm;

  logic        rf_we = 1'b0;
  logic [4:0]  rf_wa = '0;
  logic [31:0] rf_wd = '0;
  logic [31:0] regs [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_operand_fetch #(.DATA_W(32), .AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .re1(re1), .re2(re2), .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
    .reg1_data(reg1_data), .reg2_data(reg2_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_waddr(ex_waddr), .ex_wreg(ex_wreg), .ex_illegal(ex_illegal)
  );

  always @(posedge clk) begin
    if (rf_we && rf_wa != 5'd0) regs[rf_wa] <= rf_wd;
    if (re1) reg1_data <= (reg1_addr == 5'd0) ? 32'h0 :
                          (rf_we && rf_wa == reg1_addr) ? rf_wd : regs[reg1_addr];
    if (re2) reg2_data <= (reg2_addr == 5'd0) ? 32'h0 :
                          (rf_we && rf_wa == reg2_addr) ? rf_wd : regs[reg2_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] pc);
    inst       = i;
    inst_pc    = pc;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
  endtask

  task automatic pop();
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1] = 32'h5; regs[2] = 32'h11; regs[3] = 32'h22;
    reg1_data = '0; reg2_data = '0;
    reset_n = 1'b1; flush = 1'b0; inst_valid = 1'b0; ex_ready = 1'b0;
    inst = '0; inst_pc = '0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    chk("rst_inst_ready", {31'b0, inst_ready}, 32'd1);
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_re", {30'b0, re1, re2}, 32'd0);
    chk("rst_bundle", ex_rs_data | ex_imm | ex_inst | {27'b0, ex_waddr}, 32'd0);

    // add r4,r2,r3
    send(32'h00432020, 32'h100);
    chk("add_rd_re", {30'b0, re1, re2}, 32'd3);
    chk("add_rd_addr", {22'b0, reg1_addr, reg2_addr}, {22'b0, 5'd2, 5'd3});
    chk("add_rd_ready", {31'b0, inst_ready}, 32'd0);
    tick();
    chk("add_cap_re", {30'b0, re1, re2}, 32'd3);
    tick();
    chk("add_valid", {31'b0, ex_valid}, 32'd1);
    chk("add_rs", ex_rs_data, 32'h11);
    chk("add_rt", ex_rt_data, 32'h22);
    chk("add_waddr", {27'b0, ex_waddr}, 32'd4);
    chk("add_wreg", {31'b0, ex_wreg}, 32'd1);
    chk("add_pc", ex_pc, 32'h100);
    chk("add_re_off", {30'b0, re1, re2}, 32'd0);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'b0, ex_valid}, 32'd1);
      chk("bp_rs", ex_rs_data, 32'h11);
      chk("bp_inst", ex_inst, 32'h00432020);
      chk("bp_ready", {31'b0, inst_ready}, 32'd0);
    end

    // Back-to-back: ori r5,r0,0x8001
    ex_ready = 1'b1;
    #1;
    chk("b2b_ready", {31'b0, inst_ready}, 32'd1);
    send(32'h34058001, 32'h104);
    ex_ready = 1'b0;
    chk("ori_rd_re", {30'b0, re1, re2}, 32'd2);
    chk("ori_rd_valid", {31'b0, ex_valid}, 32'd0);
    tick(); tick();
    chk("ori_imm", ex_imm, 32'h00008001);
    chk("ori_rs", ex_rs_data, 32'h0);
    chk("ori_rt", ex_rt_data, 32'h0);
    chk("ori_waddr", {27'b0, ex_waddr}, 32'd5);

    // addi r5,r1,-1 back-to-back
    ex_ready = 1'b1;
    send(32'h2025FFFF, 32'h108);
    ex_ready = 1'b0;
    tick(); tick();
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_rs", ex_rs_data, 32'h5);
    pop();
    chk("idle_ready", {31'b0, inst_ready}, 32'd1);
    chk("idle_valid", {31'b0, ex_valid}, 32'd0);

    // lui r6,0x1234
    send(32'h3C061234, 32'h10C);
    chk("lui_rd_re", {30'b0, re1, re2}, 32'd0);
    tick(); tick();
    chk("lui_imm", ex_imm, 32'h12340000);
    chk("lui_waddr", {26'b0, ex_wreg, ex_waddr}, {26'b0, 1'b1, 5'd6});
    pop();

    // Write landing at the RD sample edge is bypassed
    send(32'h00432020, 32'h110);
    rf_we = 1'b1; rf_wa = 5'd2; rf_wd = 32'hAA;
    tick();
    rf_we = 1'b0;
    tick();
    chk("byp_rs", ex_rs_data, 32'hAA);
    chk("byp_rt", ex_rt_data, 32'h22);
    pop();

    // Write at the CAP edge is not seen
    send(32'h00432020, 32'h114);
    tick();
    rf_we = 1'b1; rf_wa = 5'd2; rf_wd = 32'hBB;
    tick();
    rf_we = 1'b0;
    chk("late_rs", ex_rs_data, 32'hAA);
    pop();

    // Flush in CAP
    send(32'h00432020, 32'h118);
    tick();
    flush = 1'b1;
    inst_valid = 1'b1;
    #1;
    chk("flush_re", {30'b0, re1, re2}, 32'd0);
    chk("flush_ready", {31'b0, inst_ready}, 32'd0);
    tick();
    flush = 1'b0;
    inst_valid = 1'b0;
    #1;
    chk("flush_idle_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_idle_ready", {31'b0, inst_ready}, 32'd1);
    tick();
    chk("flush_no_out", {31'b0, ex_valid}, 32'd0);

    // Illegal opcode 0x3F
    send(32'hFC421234, 32'h11C);
    chk("ill_rd_re", {30'b0, re1, re2}, 32'd0);
    tick(); tick();
    chk("ill_flag", {31'b0, ex_illegal}, 32'd1);
    chk("ill_wreg", {31'b0, ex_wreg}, 32'd0);
    chk("ill_imm", ex_imm, 32'h0);
    pop();

    // jr r2
    send(32'h00400008, 32'h120);
    chk("jr_rd_re", {30'b0, re1, re2}, 32'd2);
    tick(); tick();
    chk("jr_wreg", {31'b0, ex_wreg}, 32'd0);
    pop();

    // sw r3,4(r2)
    send(32'hAC430004, 32'h124);
    chk("sw_rd_re", {30'b0, re1, re2}, 32'd3);
    tick(); tick();
    chk("sw_bundle", {ex_imm[30:0], ex_wreg}, {31'd4, 1'b0});
    pop();

    // jal
    send(32'h0C000010, 32'h128);
    chk("jal_rd_re", {30'b0, re1, re2}, 32'd0);
    tick(); tick();
    chk("jal_waddr", {26'b0, ex_wreg, ex_waddr}, {26'b0, 1'b1, 5'd31});
    chk("jal_illegal", {31'b0, ex_illegal}, 32'd0);

    // Async reset while in OUT
    chk("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
    #2;
    reset_n = 1'b1;
    #1;
    chk("arst_valid", {31'b0, ex_valid}, 32'd0);
    chk("arst_ready", {31'b0, inst_ready}, 32'd1);
    chk("arst_re", {30'b0, re1, re2}, 32'd0);
    chk("arst_rs", ex_rs_data, 32'h0);
    tick();
    reset_n = 1'b0;
    tick();
    chk("post_rst_valid", {31'b0, ex_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_operand_fetch.md
Name: id_operand_fetch

Overview:
- Decode-side requester for the 2-read/1-write register file.
- Accepts a MIPS32 instruction from fetch on a valid/ready handshake and decodes its register fields.
- Drives the register file read ports (re1/re2, reg1_addr/reg2_addr) and captures the one-cycle-latency read data.
- Presents an operand bundle to execute on a second valid/ready handshake. Sits between the IF stage and the EX stage.

Parameters:
- DATA_W, 32, operand/instruction/PC width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of any in-flight instruction.
- inst_valid  in  1  fetch offers instruction.
- inst_ready  out  1  block accepts instruction this cycle.
- inst  in  DATA_W  instruction word.
- inst_pc  in  DATA_W  instruction PC.
- re1, re2  out  1  register-file read enables.
- reg1_addr, reg2_addr  out  AW  register-file read addresses.
- reg1_data, reg2_data  in  DATA_W  register-file read data; valid the cycle after the address/enable is sampled.
- ex_valid  out  1  operand bundle valid.
- ex_ready  in  1  execute accepts bundle.
- ex_inst, ex_pc  out  DATA_W  held instruction and PC.
- ex_rs_data, ex_rt_data  out  DATA_W  captured operands.
- ex_imm  out  DATA_W  extended immediate.
- ex_waddr  out  AW  destination register.
- ex_wreg  out  1  instruction writes a register.
- ex_illegal  out  1  unsupported opcode.

Behaviour:
- Reset (reset_n=1, async): state=IDLE. All outputs 0 except inst_ready=1.
- FSM states: IDLE, RD, CAP, OUT.
  - IDLE: inst_ready=1. On inst_valid, latch inst/inst_pc and go to RD.
  - RD: drive re1/re2/reg*_addr from the latched instruction; the register file samples them at the end of RD. Go to CAP.
  - CAP: hold the same re/addr. Capture reg1_data into ex_rs_data when re1=1, else load 0. Capture reg2_data into ex_rt_data when re2=1, else load 0. Go to OUT.
  - OUT: ex_valid=1; all ex_* outputs stable until ex_ready. inst_ready = ex_ready.
    - ex_ready & inst_valid: latch the new instruction and go to RD (back-to-back, 3 cycles per instruction).
    - ex_ready & !inst_valid: go to IDLE.
    - !ex_ready: stay in OUT.
- re1/re2/addr: 0 outside RD/CAP.
- Address r0 is still issued; the register file returns 0 for it.
- Decode (op=inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0]):
  - op 0x00: re1=re2=1, waddr=rd, wreg=1. Exception: funct 0x08 (jr) gives wreg=0, re2=0.
  - op 0x08/0x09/0x0A (addi/addiu/slti): re1=1, waddr=rt, wreg=1, imm sign-extended.
  - op 0x0C/0x0D/0x0E (andi/ori/xori): re1=1, waddr=rt, wreg=1, imm zero-extended.
  - op 0x0F (lui): no reads, waddr=rt, wreg=1, imm={inst[15:0],16'h0}.
  - op 0x23 (lw): re1=1, waddr=rt, wreg=1, imm sign-extended.
  - op 0x2B (sw): re1=re2=1, wreg=0, imm sign-extended.
  - op 0x04/0x05 (beq/bne): re1=re2=1, wreg=0, imm sign-extended.
  - op 0x02 (j): no reads, wreg=0.
  - op 0x03 (jal): no reads, waddr=31, wreg=1.
  - Any other op: ex_illegal=1, no reads, wreg=0, imm=0.
  - wreg is forced 0 when waddr=0.
- Write-through hazard: resolved by the register file's same-cycle bypass. A write landing at the RD sample edge is seen. A write in CAP or later is not seen; EX forwarding owns that case.
- flush: highest priority over every transition. Next state IDLE, ex_valid=0, re*=0. No instruction is accepted in the flush cycle (inst_ready=0 while flush=1).
- Async reset mid-RD/CAP/OUT: immediate return to IDLE; any captured operand is discarded.

Test Plan:
- Reset/idle: assert reset_n mid-OUT → ex_valid=0, inst_ready=1, re1=re2=0 asynchronously.
- R-type: regs r2=0x11, r3=0x22; inst 0x00432020 (add r4,r2,r3) → RD cycle re1=re2=1, addr 2/3. Two cycles after accept: ex_valid=1, rs=0x11, rt=0x22, waddr=4, wreg=1.
- Immediates: ori r5,r0,0x8001 → imm=0x00008001, re2=0, rt_data=0. addi r5,r1,-1 → imm=0xFFFFFFFF. lui r6,0x1234 → imm=0x12340000, re1=re2=0.
- Backpressure/back-to-back: hold ex_ready=0 for 5 cycles → bundle stable, inst_ready=0. Release with inst_valid=1 → next instruction enters RD the following cycle.
- Bypass: register file write r2=0xAA at the RD sample edge → ex_rs_data=0xAA. Same write one cycle later → old value.
- Flush/illegal: flush in CAP → IDLE next cycle, no ex_valid. op 0x3F → ex_illegal=1, wreg=0, no reads.
